// File: rtl/version_stream_pkg.sv
// Shared types and constants for the version byte-stream serialiser.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package version_stream_pkg;

  // Frame sequencing states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Payload bytes per frame: upper32 then lower32, both MSB first
  localparam int FRAME_DATA_BYTES = 8;

  // First byte of every frame unless overridden at instantiation
  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  // Index width for a requester count; a single requester still needs one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/version_streamer_rr_arbiter.sv
// Round-robin winner select: first set req bit searching from ptr+1, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the parent decides when the winner is registered.
module rr_arbiter
  import version_stream_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0]   win_idx
);

  // Scan offsets 1..NUM_REQ so the last winner is considered last
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    found      = 1'b0;
    cand       = '0;
    win_onehot = '0;
    win_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found            = 1'b1;
        win_onehot[cand] = 1'b1;
        win_idx          = cand;
      end
    end
  end

endmodule

// File: rtl/version_streamer.sv
// Frames {HEADER, upper32, lower32, xor-checksum} to a byte stream for one granted requester.
// Latency: req seen in IDLE at edge N -> gnt and HEADER valid from cycle N+1; 10 stream beats + DONE + IDLE.
// Backpressure: valid/ready; tx_data/tx_valid held while tx_ready is low, no bubbles inside a frame.
module version_streamer
  import version_stream_pkg::*;
#(
  parameter int         NUM_REQ = 2,
  parameter logic [7:0] HEADER  = DEFAULT_HEADER
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        version_upper32,
  input  logic [31:0]        version_lower32,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               done,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam logic [2:0] LAST_DATA = 3'(FRAME_DATA_BYTES - 1);

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [NUM_REQ-1:0] win_onehot;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [63:0]        shreg, shreg_nxt;
  logic [7:0]         csum, csum_nxt;
  logic [2:0]         cnt, cnt_nxt;
  logic [7:0]         tx_data_nxt;
  logic               tx_valid_nxt;
  logic               done_nxt;
  logic               accept;
  logic [7:0]         cur_byte;

  assign accept   = tx_valid && tx_ready;
  assign cur_byte = shreg[63:56];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req        (req),
    .ptr        (ptr),
    .win_onehot (win_onehot),
    .win_idx    (win_idx)
  );

  // Next-state and next-output decode; every output is registered below
  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    ptr_nxt      = ptr;
    shreg_nxt    = shreg;
    csum_nxt     = csum;
    cnt_nxt      = cnt;
    tx_data_nxt  = tx_data;
    tx_valid_nxt = tx_valid;
    done_nxt     = 1'b0;

    case (state)
      ST_IDLE: begin
        gnt_nxt      = '0;
        tx_valid_nxt = 1'b0;
        if (|req) begin
          // Snapshot versions here so later input changes cannot leak into the frame
          gnt_nxt      = win_onehot;
          ptr_nxt      = win_idx;
          shreg_nxt    = {version_upper32, version_lower32};
          csum_nxt     = '0;
          cnt_nxt      = '0;
          tx_data_nxt  = HEADER;
          tx_valid_nxt = 1'b1;
          state_nxt    = ST_HDR;
        end
      end

      ST_HDR: begin
        if (accept) begin
          tx_data_nxt = cur_byte;
          state_nxt   = ST_DATA;
        end
      end

      ST_DATA: begin
        if (accept) begin
          csum_nxt  = csum ^ cur_byte;
          shreg_nxt = {shreg[55:0], 8'h00};
          cnt_nxt   = cnt + 3'd1;
          if (cnt == LAST_DATA) begin
            // Present the finished checksum straight away to avoid a bubble
            tx_data_nxt = csum ^ cur_byte;
            state_nxt   = ST_CSUM;
          end else begin
            tx_data_nxt = shreg[55:48];
          end
        end
      end

      ST_CSUM: begin
        if (accept) begin
          tx_valid_nxt = 1'b0;
          done_nxt     = 1'b1;
          state_nxt    = ST_DONE;
        end
      end

      ST_DONE: begin
        // gnt stays up through the done cycle and drops on the way back to IDLE
        gnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end

      default: begin
        gnt_nxt      = '0;
        tx_valid_nxt = 1'b0;
        state_nxt    = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset abandons any frame in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      ptr      <= IDX_W'(NUM_REQ - 1);
      shreg    <= '0;
      csum     <= '0;
      cnt      <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      ptr      <= ptr_nxt;
      shreg    <= shreg_nxt;
      csum     <= csum_nxt;
      cnt      <= cnt_nxt;
      tx_data  <= tx_data_nxt;
      tx_valid <= tx_valid_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_version_streamer.sv
// Directed bench for version_streamer with a frame-level reference model.
// Latency: n/a.
// Backpressure: tx_ready driven always-high or random per cycle.
module tb_version_streamer;

  localparam int         N     = 2;
  localparam logic [7:0] HDR_B = 8'hA5;

  logic          clk;
  logic          rst;
  logic [31:0]   version_upper32;
  logic [31:0]   version_lower32;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic          done;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;

  version_streamer #(
    .NUM_REQ (N),
    .HEADER  (HDR_B)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .version_upper32 (version_upper32),
    .version_lower32 (version_lower32),
    .req             (req),
    .gnt             (gnt),
    .done            (done),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready)
  );

  int n_checks    = 0;
  int n_fail      = 0;
  int frames_done = 0;
  int mptr;
  bit rnd_mode    = 1'b0;

  logic [79:0]  exp_frames[$];
  logic [N-1:0] exp_gnts[$];
  logic [N-1:0] done_gnts[$];
  logic [79:0]  last_frame;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Reference frame: header, the 8 version bytes MSB first, xor of those 8 bytes
  function automatic logic [79:0] model_frame(input logic [31:0] u, input logic [31:0] l);
    logic [63:0] v;
    logic [7:0]  x;
    v = {u, l};
    x = 8'h00;
    for (int i = 0; i < 8; i++) x = x ^ v[63-8*i -: 8];
    return {HDR_B, v, x};
  endfunction

  // Reference round robin: first requester after the last winner, wrapping
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    int c;
    for (int k = 1; k <= N; k++) begin
      c = (p + k) % N;
      if (r[c]) return c;
    end
    return p;
  endfunction

  task automatic push_frame(input logic [N-1:0] r);
    int g;
    logic [N-1:0] oh;
    g = rr_pick(r, mptr);
    mptr = g;
    oh = '0;
    oh[g] = 1'b1;
    exp_frames.push_back(model_frame(version_upper32, version_lower32));
    exp_gnts.push_back(oh);
  endtask

  task automatic wait_frames(input int target, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      #1;
      if (frames_done >= target) break;
    end
    check("frames_completed", frames_done, target);
  endtask

  // tx_ready source: constant high, or a fresh random bit each cycle
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: checks stream bytes, grant, stability and done against the model
  initial begin
    logic [79:0]  cur_frame;
    logic [79:0]  act_frame;
    logic [N-1:0] cur_gnt;
    int           pos;
    bit           loaded;
    bit           stall_prev;
    logic [7:0]   prev_data;
    cur_frame  = '0;
    act_frame  = '0;
    cur_gnt    = '0;
    pos        = 0;
    loaded     = 1'b0;
    stall_prev = 1'b0;
    prev_data  = '0;
    last_frame = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        loaded     = 1'b0;
        stall_prev = 1'b0;
        pos        = 0;
      end else begin
        check("gnt_onehot0", 80'($onehot0(gnt)), 80'd1);
        if (stall_prev) begin
          check("stall_valid_held", tx_valid, 1'b1);
          check("stall_data_held", tx_data, prev_data);
        end
        if (tx_valid && !loaded) begin
          if (exp_frames.size() == 0) begin
            fail_now("unexpected_frame_start");
          end else begin
            cur_frame = exp_frames.pop_front();
            cur_gnt   = exp_gnts.pop_front();
            act_frame = '0;
            loaded    = 1'b1;
            pos       = 0;
          end
        end
        if (loaded && pos < 10) check("no_bubble", tx_valid, 1'b1);
        if (loaded && pos >= 10) check("valid_after_csum", tx_valid, 1'b0);
        if (tx_valid && loaded) check("gnt_in_frame", gnt, cur_gnt);
        if (tx_valid && tx_ready && loaded && pos < 10) begin
          check($sformatf("byte%0d", pos), tx_data, cur_frame[79-8*pos -: 8]);
          act_frame = {act_frame[71:0], tx_data};
          pos++;
        end
        if (done) begin
          if (!loaded) begin
            fail_now("spurious_done");
          end else begin
            check("done_after_10_bytes", pos, 10);
            check("gnt_at_done", gnt, cur_gnt);
            done_gnts.push_back(gnt);
            last_frame = act_frame;
            loaded = 1'b0;
            frames_done++;
          end
        end
        stall_prev = tx_valid && !tx_ready;
        prev_data  = tx_data;
      end
    end
  end

  // Directed stimulus
  initial begin
    rst             = 1'b1;
    req             = '0;
    version_upper32 = '0;
    version_lower32 = '0;
    mptr            = N - 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", gnt, 2'b00);
    check("rst_done", done, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single frame, requester 0
    version_upper32 = 32'h00000001;
    version_lower32 = 32'h000000FF;
    push_frame(2'b01);
    req = 2'b01;
    @(posedge clk);
    #1;
    check("latency_valid", tx_valid, 1'b1);
    check("latency_header", tx_data, 8'hA5);
    check("latency_gnt", gnt, 2'b01);
    req = 2'b00;
    wait_frames(1, 40);
    check("single_frame_literal", last_frame, 80'hA5_00000001_000000FF_FE);

    // Backpressure, requester 1
    rnd_mode = 1'b1;
    version_upper32 = 32'h12345678;
    version_lower32 = 32'h9ABCDEF0;
    push_frame(2'b10);
    req = 2'b10;
    @(posedge clk);
    #1;
    req = 2'b00;
    wait_frames(2, 400);
    rnd_mode = 1'b0;
    check("backpressure_literal", last_frame, 80'hA5_12345678_9ABCDEF0_00);

    // Fairness: both requesting for four frames
    version_upper32 = 32'hDEADBEEF;
    version_lower32 = 32'h01234567;
    for (int f = 0; f < 4; f++) push_frame(2'b11);
    req = 2'b11;
    wait_frames(6, 200);
    req = 2'b00;
    check("fair_gnt0", done_gnts[2], 2'b01);
    check("fair_gnt1", done_gnts[3], 2'b10);
    check("fair_gnt2", done_gnts[4], 2'b01);
    check("fair_gnt3", done_gnts[5], 2'b10);

    // Version change after the header byte
    version_upper32 = 32'hCAFEF00D;
    version_lower32 = 32'h11223344;
    push_frame(2'b01);
    req = 2'b01;
    @(posedge clk);
    #1;
    req = 2'b00;
    @(posedge clk);
    #1;
    version_lower32 = 32'hFFFFFFFF;
    wait_frames(7, 40);
    check("snapshot_literal", last_frame, 80'hA5_CAFEF00D_11223344_8D);

    // Request withdrawn right after grant
    version_upper32 = 32'h55AA00FF;
    version_lower32 = 32'h80402010;
    push_frame(2'b10);
    req = 2'b10;
    @(posedge clk);
    #1;
    check("withdraw_gnt", gnt, 2'b10);
    req = 2'b00;
    wait_frames(8, 40);
    check("withdraw_done_gnt", done_gnts[7], 2'b10);

    // Reset during data byte 3
    version_upper32 = 32'h0A0B0C0D;
    version_lower32 = 32'h01020304;
    push_frame(2'b01);
    req = 2'b01;
    @(posedge clk);
    #1;
    req = 2'b00;
    repeat (4) @(posedge clk);
    #1;
    check("pre_reset_byte3", tx_data, 8'h0D);
    rst = 1'b1;
    #1;
    check("async_rst_valid", tx_valid, 1'b0);
    check("async_rst_gnt", gnt, 2'b00);
    check("async_rst_done", done, 1'b0);
    mptr = N - 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    push_frame(2'b11);
    req = 2'b11;
    @(posedge clk);
    #1;
    check("post_reset_gnt", gnt, 2'b01);
    check("post_reset_header", tx_data, 8'hA5);
    req = 2'b00;
    wait_frames(9, 40);
    repeat (3) @(posedge clk);
    #1;
    check("frames_left", exp_frames.size(), 0);
    check("final_frame_count", frames_done, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
